// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA display timing generator.
//   Divides clk_i down to a pixel enable and runs horizontal and vertical counters.
//   From those counters it decodes, in registers, the syncs, the active-video flag and
//   the visible-pixel coordinates. It also blanks the incoming pattern colour outside
//   the visible area.
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   rgb_i          colour from the pattern generator, {R,G,B}
//   rgb_o          colour to the DAC pins, forced to 0 outside the visible area
//   hsync_o        horizontal sync (level set by SYNC_POL)
//   vsync_o        vertical sync (level set by SYNC_POL)
//   video_on_o     high while the current pixel is visible
//   row_o          current visible line, 0 while blanked
//   column_o       current visible pixel, 0 while blanked
//   frame_start_o  one-clk_i pulse when pixel (0,0) is loaded
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic        SYNC_POL  = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] rgb_i,
    output logic [2:0] rgb_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       video_on_o,
    output logic [8:0] row_o,
    output logic [9:0] column_o,
    output logic       frame_start_o
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_VISIBLE + V_FRONT + V_SYNC;

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          pix_en;

    logic          video_on_q, video_on_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic [8:0]    row_q, row_d;
    logic [9:0]    column_q, column_d;
    logic          frame_start_q, frame_start_d;

    logic          vis, h_in_sync, v_in_sync;

    // With CLK_DIV=1 the counter is stuck at 0 == DIV_LAST, so pix_en is always high.
    assign pix_en = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = pix_en ? '0 : div_cnt_q + 1'b1;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Decode from the pre-advance counters; results are captured on pix_en only.
    always_comb begin
        vis       = (32'(h_cnt_q) < H_VISIBLE) && (32'(v_cnt_q) < V_VISIBLE);
        h_in_sync = (32'(h_cnt_q) >= H_SYNC_START) && (32'(h_cnt_q) < H_SYNC_END);
        v_in_sync = (32'(v_cnt_q) >= V_SYNC_START) && (32'(v_cnt_q) < V_SYNC_END);

        video_on_d = video_on_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        row_d      = row_q;
        column_d   = column_q;
        if (pix_en) begin
            video_on_d = vis;
            hsync_d    = h_in_sync ? SYNC_POL : ~SYNC_POL;
            vsync_d    = v_in_sync ? SYNC_POL : ~SYNC_POL;
            row_d      = vis ? 9'(v_cnt_q) : 9'd0;
            column_d   = vis ? 10'(h_cnt_q) : 10'd0;
        end

        // Only true on the single pix_en edge that loads (0,0); drops on the next clk_i.
        frame_start_d = pix_en && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            video_on_q    <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            row_q         <= '0;
            column_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            row_q         <= row_d;
            column_q      <= column_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign video_on_o    = video_on_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign row_o         = row_q;
    assign column_o      = column_q;
    assign frame_start_o = frame_start_q;

    // Combinational blanking keeps a combinational pattern generator aligned with the syncs.
    assign rgb_o = video_on_q ? rgb_i : 3'b000;

endmodule
